// File: rtl/ahb_bus_initiator.sv
// Purpose : single-outstanding AHB-Lite initiator issuing key/data writes and data reads to the key/data register slave.
// Latency : accept edge T -> ADDR T+1 -> DATA T+2 -> rsp_valid T+3 (+1 per DATA wait state, +1 for the ERR cycle); illegal op responds at T+1.
// Backpres: cmd_ready only in IDLE; HREADY low stalls ADDR/DATA/ERR, bounded in DATA/ERR by the TIMEOUT wait-state limit.
//
// Ports:
//   clk, n_rst                       clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_op/cmd_wdata       command request (00 key wr, 01 data wr, 10 data rd, 11 illegal)
//   cmd_ready                        high while idle
//   rsp_valid/rsp_error/rsp_timeout  one-cycle completion pulse with status
//   rsp_rdata                        data from the last successful read
//   HADDR/HWRITE/HTRANS/HWDATA       AHB-Lite initiator outputs
//   HRDATA/HREADY/HRESP              AHB-Lite slave responses
module ahb_bus_initiator #(
    parameter logic [15:0] KEY_ADDR  = 16'h0000,
    parameter logic [15:0] DATA_ADDR = 16'h0020,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_wdata,
    output logic         cmd_ready,
    output logic         rsp_valid,
    output logic [127:0] rsp_rdata,
    output logic         rsp_error,
    output logic         rsp_timeout,
    output logic [15:0]  HADDR,
    output logic         HWRITE,
    output logic [1:0]   HTRANS,
    output logic [127:0] HWDATA,
    input  logic [127:0] HRDATA,
    input  logic         HREADY,
    input  logic         HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_KEY_WR  = 2'b00;
    localparam logic [1:0] OP_DATA_RD = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;
    localparam logic [7:0] TO_LIM     = 8'(TIMEOUT);

    state_t         state_q, state_d;
    logic [1:0]     op_q;
    logic [127:0]   wdata_q;
    logic [127:0]   rdata_q;
    logic [7:0]     wait_q, wait_d;
    logic [7:0]     wait_inc;
    logic           wait_hit;
    logic           err_q, err_d;
    logic           to_q, to_d;
    logic           rdata_ld;
    logic           cmd_acc;

    assign cmd_acc  = (state_q == S_IDLE) && cmd_valid;

    // Saturating wait-state count; a limit of zero never matches, which disables the abort.
    assign wait_inc = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    assign wait_hit = (TO_LIM != 8'd0) && (wait_inc == TO_LIM);

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        to_d     = to_q;
        rdata_ld = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                to_d  = 1'b0;
                if (cmd_valid) begin
                    if (cmd_op == OP_ILLEGAL) begin
                        // Illegal op completes without touching the bus.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                // Address-phase stalls are not counted against the timeout.
                if (HREADY) begin
                    state_d = S_DATA;
                    wait_d  = 8'd0;
                end
            end
            S_DATA: begin
                case ({HREADY, HRESP})
                    2'b10: begin
                        state_d  = S_DONE;
                        rdata_ld = (op_q == OP_DATA_RD);
                    end
                    2'b01: state_d = S_ERR;
                    2'b11: begin
                        // Single-cycle ERROR is a protocol violation; still reported as an error.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                    default: begin
                        wait_d = wait_inc;
                        if (wait_hit) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                            to_d    = 1'b1;
                        end
                    end
                endcase
            end
            S_ERR: begin
                if (HREADY) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc;
                    if (wait_hit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        to_d    = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            to_q    <= to_d;
            if (cmd_acc) begin
                op_q    <= cmd_op;
                wdata_q <= cmd_wdata;
            end
            if (rdata_ld) begin
                rdata_q <= HRDATA;
            end
        end
    end

    // All outputs decode registered state only; HREADY/HRESP never reach them combinationally.
    // op 11 never reaches ADDR/DATA, so op_q[1]==0 identifies a write in those states.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        rsp_valid   = (state_q == S_DONE);
        rsp_error   = (state_q == S_DONE) && err_q;
        rsp_timeout = (state_q == S_DONE) && to_q;
        rsp_rdata   = rdata_q;
        HTRANS      = 2'b00;
        HADDR       = 16'h0000;
        HWRITE      = 1'b0;
        HWDATA      = '0;
        if (state_q == S_ADDR) begin
            HTRANS = 2'b10;
            HADDR  = (op_q == OP_KEY_WR) ? KEY_ADDR : DATA_ADDR;
            HWRITE = ~op_q[1];
        end
        if ((state_q == S_DATA) && !op_q[1]) begin
            HWDATA = wdata_q;
        end
    end

endmodule

// File: tb/tb_ahb_bus_initiator.sv
module tb_ahb_bus_initiator;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [127:0] cmd_wdata;
    logic         cmd_ready;
    logic         rsp_valid;
    logic [127:0] rsp_rdata;
    logic         rsp_error;
    logic         rsp_timeout;
    logic [15:0]  HADDR;
    logic         HWRITE;
    logic [1:0]   HTRANS;
    logic [127:0] HWDATA;
    logic [127:0] HRDATA;
    logic         HREADY;
    logic         HRESP;

    int checks = 0;
    int errors = 0;
    logic [127:0] model_rdata;

    ahb_bus_initiator #(
        .KEY_ADDR (16'h0000),
        .DATA_ADDR(16'h0020),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HTRANS     (HTRANS),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One command. The bus responder follows a script: 'a' HREADY-low cycles in the address
    // phase, 'w' wait states in the data phase, then outcome 0=OKAY, 1=two-cycle ERROR,
    // 2=single-cycle ERROR (violation). Expected completion cycle comes from the transfer rules.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [127:0] wd,
                           input int a, input int w, input int outc, input logic [127:0] rd);
        int d;
        int j;
        logic e_err, e_to, e_vld;
        logic [1:0] e_tr;
        logic [15:0] e_addr;
        if (op == 2'b11) begin
            d = 1; e_err = 1'b1; e_to = 1'b0;
        end else if (w >= TO) begin
            d = a + 2 + TO; e_err = 1'b1; e_to = 1'b1;
        end else if (outc == 0) begin
            d = a + 3 + w; e_err = 1'b0; e_to = 1'b0;
        end else if (outc == 1) begin
            d = a + 4 + w; e_err = 1'b1; e_to = 1'b0;
        end else begin
            d = a + 3 + w; e_err = 1'b1; e_to = 1'b0;
        end
        e_addr = (op == 2'b00) ? 16'h0000 : 16'h0020;

        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
        HREADY = 1'b1; HRESP = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_wdata = rand128();
            if (k <= d) begin
                e_vld = (k == d);
                e_tr  = (op != 2'b11 && k <= a + 1) ? 2'b10 : 2'b00;
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL %s cmd_ready cyc %0d got %b want 0", tag, k, cmd_ready);
                end
                checks++;
                if (rsp_valid !== e_vld) begin
                    errors++; $display("FAIL %s rsp_valid cyc %0d got %b want %b", tag, k, rsp_valid, e_vld);
                end
                checks++;
                if (HTRANS !== e_tr) begin
                    errors++; $display("FAIL %s HTRANS cyc %0d got %b want %b", tag, k, HTRANS, e_tr);
                end
                checks++;
                if (HADDR !== ((e_tr == 2'b10) ? e_addr : 16'h0000)) begin
                    errors++; $display("FAIL %s HADDR cyc %0d got %h want %h", tag, k, HADDR,
                                       (e_tr == 2'b10) ? e_addr : 16'h0000);
                end
                checks++;
                if (HWRITE !== (e_tr == 2'b10 && op != 2'b10)) begin
                    errors++; $display("FAIL %s HWRITE cyc %0d got %b want %b", tag, k, HWRITE,
                                       (e_tr == 2'b10 && op != 2'b10));
                end
                if (op != 2'b11 && k == a + 2) begin
                    checks++;
                    if (HWDATA !== ((op == 2'b10) ? 128'd0 : wd)) begin
                        errors++; $display("FAIL %s HWDATA cyc %0d got %h want %h", tag, k, HWDATA,
                                           (op == 2'b10) ? 128'd0 : wd);
                    end
                end
                if (k == d) begin
                    if (op == 2'b10 && !e_err) model_rdata = rd;
                    checks++;
                    if (rsp_error !== e_err) begin
                        errors++; $display("FAIL %s rsp_error got %b want %b", tag, rsp_error, e_err);
                    end
                    checks++;
                    if (rsp_timeout !== e_to) begin
                        errors++; $display("FAIL %s rsp_timeout got %b want %b", tag, rsp_timeout, e_to);
                    end
                    checks++;
                    if (rsp_rdata !== model_rdata) begin
                        errors++; $display("FAIL %s rsp_rdata got %h want %h", tag, rsp_rdata, model_rdata);
                    end
                end else begin
                    checks++;
                    if (rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
                        errors++; $display("FAIL %s status outside done cyc %0d got %b%b want 00",
                                           tag, k, rsp_error, rsp_timeout);
                    end
                end
                // Bus response for cycle k.
                j = k - (a + 1);
                HRDATA = rand128(); HREADY = 1'b1; HRESP = 1'b0;
                if (op != 2'b11) begin
                    if (k <= a) begin
                        HREADY = 1'b0;
                    end else if (j >= 1 && j <= w) begin
                        HREADY = 1'b0;
                    end else if (j == w + 1) begin
                        if (outc == 0) HRDATA = rd;
                        else if (outc == 1) begin HREADY = 1'b0; HRESP = 1'b1; end
                        else HRESP = 1'b1;
                    end else if (j == w + 2 && outc == 1) begin
                        HRESP = 1'b1;
                    end
                end
            end else begin
                checks++;
                if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL %s back to idle got ready=%b valid=%b want 1/0",
                                       tag, cmd_ready, rsp_valid);
                end
            end
        end
        HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL %s ctl got rdy=%b vld=%b err=%b to=%b want 1000",
                               tag, cmd_ready, rsp_valid, rsp_error, rsp_timeout);
        end
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 16'h0000 || HWRITE !== 1'b0) begin
            errors++; $display("FAIL %s addr-phase got %b %h %b want 00 0000 0", tag, HTRANS, HADDR, HWRITE);
        end
        checks++;
        if (HWDATA !== 128'd0) begin
            errors++; $display("FAIL %s HWDATA got %h want 0", tag, HWDATA);
        end
        checks++;
        if (rsp_rdata !== 128'd0) begin
            errors++; $display("FAIL %s rsp_rdata got %h want 0", tag, rsp_rdata);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_key();
        run_txn("write_key", 2'b00, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 0, 0, '0);
    endtask

    task automatic test_read_waits();
        run_txn("read_waits", 2'b10, rand128(), 0, 3, 0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    endtask

    task automatic test_error();
        run_txn("error_resp", 2'b01, rand128(), 0, 0, 1, '0);
        run_txn("violation", 2'b10, rand128(), 0, 1, 2, rand128());
    endtask

    task automatic test_timeout();
        run_txn("timeout", 2'b10, rand128(), 0, 40, 0, rand128());
        run_txn("after_timeout", 2'b01, rand128(), 0, 0, 0, '0);
    endtask

    task automatic test_illegal_and_stall();
        run_txn("illegal", 2'b11, rand128(), 0, 0, 0, '0);
        run_txn("addr_stall", 2'b10, rand128(), 2, 0, 0, rand128());
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            run_txn("random", 2'($urandom_range(0, 3)), rand128(), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), rand128());
        end
    endtask

    task automatic test_reset_mid();
        // Guarantee a non-zero read value is held before the reset.
        run_txn("pre_reset_read", 2'b10, rand128(), 0, 0, 0, 128'h1 | rand128());
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_wdata = rand128();
        @(posedge clk);
        @(negedge clk);                 // ADDR
        cmd_valid = 1'b0; HREADY = 1'b1;
        @(negedge clk);                 // DATA
        HREADY = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        model_rdata = '0;
        check_reset_values("reset_mid");
        HREADY = 1'b1; HRDATA = rand128();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_mid rsp_valid held cyc %0d got %b want 0", i, rsp_valid);
            end
        end
        n_rst = 1'b1;
        @(negedge clk);
        run_txn("post_reset", 2'b00, rand128(), 0, 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_write_key();
        test_read_waits();
        test_error();
        test_timeout();
        test_illegal_and_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
